sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the entry count; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL have parameter AFULL_TH, default DEPTH-2, giving the occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AEMPTY_TH, default 2, giving the occupancy at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all logic samples on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 w_en  input  1  write request.
REQ-008 data_in  input  DATA_W  write data.
REQ-009 r_en  input  1  read request.
REQ-010 data_out  output  DATA_W  registered read data.
REQ-011 rd_valid  output  1  one-cycle pulse: data_out carries a newly read word.
REQ-012 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-013 count  output  AW+1, where AW = log2(DEPTH)  current occupancy, range 0..DEPTH.
REQ-014 overflow, underflow  output  1 each  sticky error flags; present only per REQ-030.

Function
REQ-015 The write pointer and read pointer SHALL each be AW+1 bits wide: AW address bits plus one wrap bit, with natural modulo wrap.
REQ-016 empty SHALL equal 1 when the two pointers are identical.
REQ-017 full SHALL equal 1 when the address bits are equal and the wrap bits differ; all DEPTH entries are usable.
REQ-018 A write SHALL be accepted when w_en=1 and full=0; data_in is stored at the write address and the write pointer increments.
REQ-019 A read SHALL be accepted when r_en=1 and empty=0; the read pointer increments.
REQ-020 On an accepted read, data_out SHALL update on the next clock edge and rd_valid SHALL pulse high for one cycle (read latency 1).
REQ-021 When no read is accepted, data_out SHALL hold its last value and rd_valid SHALL be 0.
REQ-022 When a write and a read are both accepted in one cycle, both SHALL complete and count SHALL be unchanged.
REQ-023 When full, a simultaneous w_en and r_en SHALL perform the read only; the write is dropped.
REQ-024 When empty, a simultaneous w_en and r_en SHALL perform the write only; there is no read-through and rd_valid stays 0.
REQ-025 count SHALL be registered and SHALL change by +1 on a write only, -1 on a read only, and 0 otherwise.
REQ-026 The flags full, empty, almost_full and almost_empty SHALL be decoded combinationally from the registered pointers and count, and SHALL be valid in the same cycle.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set both pointers to 0, count to 0, data_out to 0 and rd_valid to 0; any w_en or r_en in that cycle is ignored.
REQ-028 After reset the outputs SHALL read empty=1, almost_empty=1, full=0 and almost_full=0; memory contents are not reset and are don't-care.
REQ-029 A reset asserted mid-operation SHALL discard all stored entries in that same edge.

Configuration
REQ-030 Macro SYNC_FIFO_ERR_FLAGS_EN SHALL control the error flags.
- Defined: overflow sets on w_en while full; underflow sets on r_en while empty; each stays set until rst.
- Not defined: the overflow and underflow ports SHALL be absent, and rejected requests are silently dropped.

Structure
REQ-031 Package sync_fifo_pkg SHALL hold the default-width constants and a pointer typedef helper.
REQ-032 Storage SHALL be the sub-module fifo_mem_2p: DATA_W by DEPTH, one synchronous write port, one registered read port, no reset.
REQ-033 Pointer, count and flag logic SHALL reside in sync_fifo_param.

Verification (DATA_W=8, DEPTH=4, AFULL_TH=3, AEMPTY_TH=1)
REQ-034 Bench SHALL cover reset: rst for 2 cycles -> empty=1, count=0, data_out=0x00, rd_valid=0.
REQ-035 Bench SHALL cover fill and drain: write 0x11, 0x22, 0x33, 0x44 -> full=1, count=4, almost_full asserted from count 3; then 4 reads -> data_out 0x11..0x44 each one cycle after r_en, empty=1.
REQ-036 Bench SHALL cover write while full: w_en with 0x55 -> count stays 4, 0x55 never read back, overflow=1 with macro defined.
REQ-037 Bench SHALL cover simultaneous access when full: w_en and r_en with 0x66 -> read of 0x11 completes, write dropped, count=3.
REQ-038 Bench SHALL cover wrap-around: 10 write-then-read pairs with values 0..9 -> outputs 0..9 in order, pointers wrap and count stays within 0..1.
REQ-039 Bench SHALL cover reset mid-operation: 2 words stored, then rst -> empty=1; following read -> rd_valid=0, underflow=1 with macro defined.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and pointer helpers for the synchronous FIFO.
// The optional sticky error flags are enabled by SYNC_FIFO_ERR_FLAGS_EN.
package sync_fifo_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int DEPTH_DEF     = 16;
  localparam int AEMPTY_TH_DEF = 2;

  // A pointer holds the address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = ptr_width(DEPTH_DEF);

  typedef logic [PTR_W_DEF-1:0] ptr_def_t;

endpackage : sync_fifo_pkg

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: synchronous write port, registered read port.
module fifo_mem_2p #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset so they map onto
  // plain RAM; the FIFO top masks the read data until a first read.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule : fifo_mem_2p

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with occupancy flags and registered read data.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = AEMPTY_TH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     r_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                     overflow,
  output logic                     underflow
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t AFULL_LVL  = PTR_W'(AFULL_TH);
  localparam ptr_t AEMPTY_LVL = PTR_W'(AEMPTY_TH);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t count_q, count_d;
  logic rd_valid_q;
  logic rd_seen_q;
  logic wr_accept, rd_accept;
  logic [DATA_W-1:0] mem_rdata;

  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign almost_full  = (count_q >= AFULL_LVL);
  assign almost_empty = (count_q <= AEMPTY_LVL);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_accept = w_en && !full && !rst;
    rd_accept = r_en && !empty && !rst;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_accept;
      if (rd_accept) rd_seen_q <= 1'b1;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (data_in),
    .re_i    (rd_accept),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Until the first read after reset the uninitialised read register is hidden.
  assign data_out = rd_seen_q ? mem_rdata : '0;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (w_en && full)  overflow_q  <= 1'b1;
      if (r_en && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// Directed, table-driven bench for sync_fifo_param (DATA_W=8, DEPTH=4).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en;
  logic [7:0] data_in;
  logic       r_en;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W    (8),
    .DEPTH     (4),
    .AFULL_TH  (3),
    .AEMPTY_TH (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .data_in      (data_in),
    .r_en         (r_en),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  typedef struct {
    logic       rst, w;
    logic [7:0] din;
    logic       r;
    logic [2:0] cnt;
    logic       full, empty, af, ae, rv;
    logic [7:0] dout;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic s_rst, input logic s_w, input logic [7:0] s_d, input logic s_r);
    rst     = s_rst;
    w_en    = s_w;
    data_in = s_d;
    r_en    = s_r;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic s_rst, input logic s_w, input logic [7:0] s_d,
                              input logic s_r, input logic [2:0] c, input logic f,
                              input logic e, input logic af, input logic ae,
                              input logic rv, input logic [7:0] dout,
                              input logic ovf, input logic unf);
    vec_t v;
    v.rst = s_rst; v.w = s_w; v.din = s_d; v.r = s_r;
    v.cnt = c; v.full = f; v.empty = e; v.af = af; v.ae = ae;
    v.rv = rv; v.dout = dout; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  initial begin
    //            rst w  din    r  cnt full emp af ae rv dout   ovf unf
    vecs.push_back(mk(1, 0, 8'h00, 0, 0,  0,  1,  0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 1, 8'h99, 1, 0,  0,  1,  0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 1,  0,  0,  0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 2,  0,  0,  0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 3,  0,  0,  1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h44, 0, 4,  1,  0,  1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h55, 0, 4,  1,  0,  1, 0, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3,  0,  0,  1, 0, 1, 8'h11, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 2,  0,  0,  0, 0, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1,  0,  0,  0, 1, 1, 8'h33, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0,  0,  1,  0, 1, 1, 8'h44, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0,  0,  1,  0, 1, 0, 8'h44, 1, 0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 1,  0,  0,  0, 1, 0, 8'h44, 1, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 2,  0,  0,  0, 0, 0, 8'h44, 1, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 3,  0,  0,  1, 0, 0, 8'h44, 1, 0));
    vecs.push_back(mk(0, 1, 8'h44, 0, 4,  1,  0,  1, 0, 0, 8'h44, 1, 0));
    vecs.push_back(mk(0, 1, 8'h66, 1, 3,  0,  0,  1, 0, 1, 8'h11, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 2,  0,  0,  0, 0, 1, 8'h22, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1,  0,  0,  0, 1, 1, 8'h33, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0,  0,  1,  0, 1, 1, 8'h44, 1, 0));
    vecs.push_back(mk(0, 1, 8'h77, 1, 1,  0,  0,  0, 1, 0, 8'h44, 1, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0,  0,  1,  0, 1, 1, 8'h77, 1, 1));

    rst = 1'b1; w_en = 1'b0; data_in = 8'h00; r_en = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].w, vecs[i].din, vecs[i].r);
      check($sformatf("v%0d count", i),        32'(count),        32'(vecs[i].cnt));
      check($sformatf("v%0d full", i),         32'(full),         32'(vecs[i].full));
      check($sformatf("v%0d empty", i),        32'(empty),        32'(vecs[i].empty));
      check($sformatf("v%0d almost_full", i),  32'(almost_full),  32'(vecs[i].af));
      check($sformatf("v%0d almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
      check($sformatf("v%0d rd_valid", i),     32'(rd_valid),     32'(vecs[i].rv));
      check($sformatf("v%0d data_out", i),     32'(data_out),     32'(vecs[i].dout));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      check($sformatf("v%0d overflow", i),     32'(overflow),     32'(vecs[i].ovf));
      check($sformatf("v%0d underflow", i),    32'(underflow),    32'(vecs[i].unf));
`endif
    end

    // Wrap-around: write-then-read pairs carry the pointers across several wraps.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'(i), 0);
      check($sformatf("wrap%0d count_after_wr", i), 32'(count), 32'd1);
      check($sformatf("wrap%0d empty_after_wr", i), 32'(empty), 32'd0);
      step(0, 0, 8'h00, 1);
      check($sformatf("wrap%0d rd_valid", i),       32'(rd_valid), 32'd1);
      check($sformatf("wrap%0d data_out", i),       32'(data_out), 32'(i));
      check($sformatf("wrap%0d count_after_rd", i), 32'(count),    32'd0);
    end

    // Reset mid-operation discards stored entries and clears sticky flags.
    step(0, 1, 8'hAA, 0);
    step(0, 1, 8'hBB, 0);
    check("mid count_before_rst", 32'(count), 32'd2);
    step(1, 1, 8'hCC, 1);
    check("mid empty_after_rst",    32'(empty),        32'd1);
    check("mid count_after_rst",    32'(count),        32'd0);
    check("mid data_out_after_rst", 32'(data_out),     32'h00);
    check("mid rd_valid_after_rst", 32'(rd_valid),     32'd0);
    check("mid aempty_after_rst",   32'(almost_empty), 32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("mid overflow_cleared",   32'(overflow),     32'd0);
    check("mid underflow_cleared",  32'(underflow),    32'd0);
`endif
    step(0, 0, 8'h00, 1);
    check("mid rd_valid_on_empty",  32'(rd_valid),     32'd0);
    check("mid data_out_on_empty",  32'(data_out),     32'h00);
    check("mid empty_on_empty",     32'(empty),        32'd1);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("mid underflow_set",      32'(underflow),    32'd1);
`endif
    step(0, 1, 8'hCC, 0);
    step(0, 0, 8'h00, 1);
    check("post_rst readback",      32'(data_out),     32'hCC);
    check("post_rst rd_valid",      32'(rd_valid),     32'd1);
    step(0, 0, 8'h00, 0);
    check("post_rst rd_valid_drop", 32'(rd_valid),     32'd0);
    check("post_rst data_hold",     32'(data_out),     32'hCC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_sync_fifo_param
